// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame constants and baud-rate codes.
// The codes and divider table are common to the transmit and receive sides.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  localparam int unsigned BaudCntW = 14;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  // clk cycles per oversampling tick for a 50 MHz system clock: 50e6 / (16 * baud).
  function automatic logic [BaudCntW-1:0] baud_period(input logic [2:0] code);
    logic [BaudCntW-1:0] period;
    case (code)
      BAUD_300:    period = 14'd10417;
      BAUD_1200:   period = 14'd2604;
      BAUD_4800:   period = 14'd651;
      BAUD_9600:   period = 14'd326;
      BAUD_19200:  period = 14'd163;
      BAUD_38400:  period = 14'd81;
      BAUD_57600:  period = 14'd54;
      BAUD_115200: period = 14'd27;
      default:     period = 14'd27;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Free-running divider producing the one-cycle sample_ENABLE tick at 16x the selected baud.
// The comparison is >= so a code change never strands the counter above the new period.
module baud_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);
  import uart_pkg::*;

  logic [BaudCntW-1:0] period;
  logic [BaudCntW-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;

  assign period = baud_period(baud_select);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q >= period - 1'b1) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign sample_ENABLE = tick_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (11-bit frame); otherwise the frame is 10 bits.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 TxD,
  output logic                 Tx_BUSY
);
  import uart_pkg::*;

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_BITS);
  localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           baud_q, baud_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 sample_enable;
  logic [2:0]           baud_mux;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // The latched code holds the bit rate steady for the whole frame.
  assign baud_mux = busy_q ? baud_q : baud_select;

  baud_controller u_baud_controller (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_mux),
    .sample_ENABLE (sample_enable)
  );

  assign accept  = Tx_WR && Tx_EN && !busy_q;
  assign bit_end = sample_enable && (tick_cnt_q == TickMax);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != StIdle && sample_enable) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          shift_d    = Tx_DATA;
          baud_d     = baud_select;
          tick_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^Tx_DATA;
`endif
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxLast) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so TxD and Tx_BUSY change on the same edge.
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      baud_q     <= 3'b000;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule
